// File: rtl/ms_hsiao_ecc_check.sv
// Two-stage Hsiao SEC-DED check pipeline. The address is folded into the check bits but is not
// stored. Saturating error counters and a first-error capture sit on the output handshake.
module ms_hsiao_ecc_check #(
    parameter int unsigned CDataW = 32,
    parameter int unsigned CAddrW = 18,
    parameter int unsigned CChkW  = 7,
    parameter logic [CChkW-1:0][CAddrW+CDataW-1:0] CSens = {
        50'h054F7C5C35996, 50'h22AED9C3C5553, 50'h161DE5999AC39, 50'h098BFCA55A3C9,
        50'h3867A35CC9335, 50'h381F933335CCC, 50'h07F0733333333},
    parameter int unsigned CCntW  = 16
) (
    input  logic                    AClkH,
    input  logic                    AResetH,
    input  logic                    AVldI,
    output logic                    ARdyO,
    input  logic [CAddrW-1:0]       AAddrI,
    input  logic [CChkW+CDataW-1:0] ADataI,
    input  logic                    ACorrEn,
    output logic                    AVldO,
    input  logic                    ARdyI,
    output logic [CDataW-1:0]       ADataO,
    output logic                    ASecO,
    output logic                    ADedO,
    output logic [CChkW-1:0]        ASyndO,
    output logic [CCntW-1:0]        ASecCnt,
    output logic [CCntW-1:0]        ADedCnt,
    output logic                    ALogVld,
    output logic [CAddrW-1:0]       ALogAddr,
    output logic [CChkW-1:0]        ALogSynd,
    input  logic                    ALogClr
);

    localparam logic [CChkW-1:0] CSyndOne = 1;
    localparam logic [CCntW-1:0] CCntOne  = 1;
    localparam logic [CCntW-1:0] CCntMax  = {CCntW{1'b1}};

    // Stage 1 state
    logic                    r_s1_vld;
    logic [CAddrW-1:0]       r_s1_addr;
    logic [CDataW-1:0]       r_s1_data;
    logic [CChkW-1:0]        r_s1_synd;
    logic                    r_s1_corr;
    // Stage 2 state
    logic                    r_s2_vld;
    logic [CAddrW-1:0]       r_s2_addr;
    logic [CDataW-1:0]       r_s2_data;
    logic                    r_s2_sec;
    logic                    r_s2_ded;
    logic [CChkW-1:0]        r_s2_synd;
    // Counters and capture
    logic [CCntW-1:0]        r_sec_cnt;
    logic [CCntW-1:0]        r_ded_cnt;
    logic                    r_log_vld;
    logic [CAddrW-1:0]       r_log_addr;
    logic [CChkW-1:0]        r_log_synd;

    logic                    w_s1_adv;
    logic                    w_s2_adv;
    logic                    w_hs;
    logic [CChkW-1:0]        w_synd_in;
    logic [CChkW-1:0]        w_col;
    logic [CDataW-1:0]       w_flip;
    logic                    w_data_hit;
    logic                    w_unit;
    logic                    w_sec;
    logic                    w_ded;
    logic [CDataW-1:0]       w_data_fix;
    logic [CCntW-1:0]        w_sec_base;
    logic [CCntW-1:0]        w_ded_base;
    logic [CCntW-1:0]        w_sec_nxt;
    logic [CCntW-1:0]        w_ded_nxt;
    logic                    w_log_base;

    assign w_s2_adv = ~r_s2_vld | ARdyI;
    assign w_s1_adv = ~r_s1_vld | w_s2_adv;
    assign w_hs     = r_s2_vld & ARdyI;
    assign ARdyO    = w_s1_adv;

    // Syndrome of the incoming word: parity of selected {addr,data} bits against stored check
    always_comb begin
        w_synd_in = '0;
        for (int i = 0; i < CChkW; i++) begin
            w_synd_in[i] = (^({AAddrI, ADataI[CDataW-1:0]} & CSens[i])) ^ ADataI[CDataW+i];
        end
    end

    // Match the stage-1 syndrome to a data column; the first matching column wins
    always_comb begin
        w_flip     = '0;
        w_data_hit = 1'b0;
        w_col      = '0;
        for (int k = 0; k < CDataW; k++) begin
            for (int i = 0; i < CChkW; i++) begin
                w_col[i] = CSens[i][k];
            end
            if (!w_data_hit && (r_s1_synd == w_col)) begin
                w_flip[k]  = 1'b1;
                w_data_hit = 1'b1;
            end
        end
    end

    // Address-column, even-weight and unmatched odd syndromes all fall into DED
    assign w_unit     = (r_s1_synd != '0) && ((r_s1_synd & (r_s1_synd - CSyndOne)) == '0);
    assign w_sec      = w_data_hit | w_unit;
    assign w_ded      = (r_s1_synd != '0) & ~w_sec;
    assign w_data_fix = r_s1_data ^ (r_s1_corr ? w_flip : '0);

    // Clear is applied before the coincident handshake is counted or captured
    always_comb begin
        w_sec_base = ALogClr ? '0 : r_sec_cnt;
        w_ded_base = ALogClr ? '0 : r_ded_cnt;
        w_log_base = ALogClr ? 1'b0 : r_log_vld;
        w_sec_nxt  = w_sec_base;
        w_ded_nxt  = w_ded_base;
        if (w_hs && r_s2_sec && (w_sec_base != CCntMax)) begin
            w_sec_nxt = w_sec_base + CCntOne;
        end
        if (w_hs && r_s2_ded && (w_ded_base != CCntMax)) begin
            w_ded_nxt = w_ded_base + CCntOne;
        end
    end

    // Stage 1: register address, data, syndrome and correction enable on accept
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            r_s1_vld  <= 1'b0;
            r_s1_addr <= '0;
            r_s1_data <= '0;
            r_s1_synd <= '0;
            r_s1_corr <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_vld <= AVldI;
            if (AVldI) begin
                r_s1_addr <= AAddrI;
                r_s1_data <= ADataI[CDataW-1:0];
                r_s1_synd <= w_synd_in;
                r_s1_corr <= ACorrEn;
            end
        end
    end

    // Stage 2: register corrected data and flags; payload only moves with a valid word
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            r_s2_vld  <= 1'b0;
            r_s2_addr <= '0;
            r_s2_data <= '0;
            r_s2_sec  <= 1'b0;
            r_s2_ded  <= 1'b0;
            r_s2_synd <= '0;
        end else if (w_s2_adv) begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_addr <= r_s1_addr;
                r_s2_data <= w_data_fix;
                r_s2_sec  <= w_sec;
                r_s2_ded  <= w_ded;
                r_s2_synd <= r_s1_synd;
            end
        end
    end

    // Saturating counters and first-error capture
    always_ff @(posedge AClkH or posedge AResetH) begin
        if (AResetH) begin
            r_sec_cnt  <= '0;
            r_ded_cnt  <= '0;
            r_log_vld  <= 1'b0;
            r_log_addr <= '0;
            r_log_synd <= '0;
        end else begin
            r_sec_cnt <= w_sec_nxt;
            r_ded_cnt <= w_ded_nxt;
            if (w_hs && (r_s2_sec || r_s2_ded) && !w_log_base) begin
                r_log_vld  <= 1'b1;
                r_log_addr <= r_s2_addr;
                r_log_synd <= r_s2_synd;
            end else if (ALogClr) begin
                r_log_vld  <= 1'b0;
                r_log_addr <= '0;
                r_log_synd <= '0;
            end
        end
    end

    assign AVldO    = r_s2_vld;
    assign ADataO   = r_s2_data;
    assign ASecO    = r_s2_sec;
    assign ADedO    = r_s2_ded;
    assign ASyndO   = r_s2_synd;
    assign ASecCnt  = r_sec_cnt;
    assign ADedCnt  = r_ded_cnt;
    assign ALogVld  = r_log_vld;
    assign ALogAddr = r_log_addr;
    assign ALogSynd = r_log_synd;

endmodule

// File: tb/tb_ms_hsiao_ecc_check.sv
// Bench for ms_hsiao_ecc_check: directed table, stall/reset/saturation sequences and random
// traffic scored against a behavioural model.
module tb_ms_hsiao_ecc_check;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 18;
    localparam int unsigned CW = 7;
    localparam int unsigned NW = 4;
    localparam int CNT_MAX = (1 << NW) - 1;
    localparam logic [CW-1:0][AW+DW-1:0] ROWS = {
        50'h054F7C5C35996, 50'h22AED9C3C5553, 50'h161DE5999AC39, 50'h098BFCA55A3C9,
        50'h3867A35CC9335, 50'h381F933335CCC, 50'h07F0733333333};

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          sec;
        logic          ded;
        logic [CW-1:0] synd;
    } exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [CW-1:0] chk;
        logic          corr;
        logic [DW-1:0] exp_data;
        logic          exp_sec;
        logic          exp_ded;
    } vec_t;

    logic             clk, rst;
    logic             vld_i, rdy_o, corr_i, vld_o, rdy_i;
    logic [AW-1:0]    addr_i, log_addr;
    logic [CW+DW-1:0] data_i;
    logic [DW-1:0]    data_o;
    logic             sec_o, ded_o, log_vld, log_clr;
    logic [CW-1:0]    synd_o, log_synd;
    logic [NW-1:0]    sec_cnt, ded_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    int            m_sec, m_ded;
    logic          m_lvld;
    logic [AW-1:0] m_laddr;
    logic [CW-1:0] m_lsynd;

    logic          held;
    logic [DW-1:0] h_data;
    logic          h_sec, h_ded;
    logic [CW-1:0] h_synd;

    ms_hsiao_ecc_check #(.CCntW(NW)) dut (
        .AClkH(clk), .AResetH(rst), .AVldI(vld_i), .ARdyO(rdy_o), .AAddrI(addr_i),
        .ADataI(data_i), .ACorrEn(corr_i), .AVldO(vld_o), .ARdyI(rdy_i), .ADataO(data_o),
        .ASecO(sec_o), .ADedO(ded_o), .ASyndO(synd_o), .ASecCnt(sec_cnt), .ADedCnt(ded_cnt),
        .ALogVld(log_vld), .ALogAddr(log_addr), .ALogSynd(log_synd), .ALogClr(log_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [CW-1:0] synd_of(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                              input logic [CW-1:0] c);
        logic [AW+DW-1:0] v;
        logic [CW-1:0]    s;
        v = {a, d};
        for (int i = 0; i < CW; i++) s[i] = (^(v & ROWS[i])) ^ c[i];
        return s;
    endfunction

    function automatic logic [CW-1:0] enc(input logic [AW-1:0] a, input logic [DW-1:0] d);
        return synd_of(a, d, '0);
    endfunction

    // Explain the syndrome as a single data-bit flip, else a single check-bit flip, else DED
    function automatic exp_t predict(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                     input logic [CW-1:0] c, input logic corr);
        exp_t          e;
        logic [DW-1:0] b;
        bit            found;
        e.addr = a; e.data = d; e.sec = 1'b0; e.ded = 1'b0;
        e.synd = synd_of(a, d, c);
        found  = 0;
        if (e.synd != '0) begin
            for (int j = 0; j < DW; j++) begin
                b = '0;
                b[j] = 1'b1;
                if (!found && enc('0, b) == e.synd) begin
                    found = 1;
                    if (corr) e.data = d ^ b;
                end
            end
            if (found || $countones(e.synd) == 1) e.sec = 1'b1;
            else e.ded = 1'b1;
        end
        return e;
    endfunction

    function automatic vec_t mkvec(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                   input logic [CW-1:0] c, input logic corr,
                                   input logic [DW-1:0] ed, input logic es, input logic eded);
        vec_t v;
        v.addr = a; v.data = d; v.chk = c; v.corr = corr;
        v.exp_data = ed; v.exp_sec = es; v.exp_ded = eded;
        return v;
    endfunction

    // Present one word and push its expectation when it is accepted
    task automatic send(input logic [AW-1:0] a, input logic [CW+DW-1:0] w, input logic corr,
                        input exp_t e);
        bit done;
        done   = 0;
        vld_i  = 1'b1;
        addr_i = a;
        data_i = w;
        corr_i = corr;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (rdy_o) begin
                q.push_back(e);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        vld_i = 1'b0;
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got rdy 0, expected accept within 100 cycles");
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #1;
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Output scoreboard plus counter/capture model, sampled mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            m_sec = 0; m_ded = 0; m_lvld = 1'b0; m_laddr = '0; m_lsynd = '0;
            held = 1'b0;
        end else begin
            check("sec_cnt", 64'(sec_cnt), 64'(m_sec));
            check("ded_cnt", 64'(ded_cnt), 64'(m_ded));
            check("log_vld", 64'(log_vld), 64'(m_lvld));
            check("log_addr", 64'(log_addr), 64'(m_laddr));
            check("log_synd", 64'(log_synd), 64'(m_lsynd));
            if (vld_o) begin
                if (held) begin
                    check("stall_data", 64'(data_o), 64'(h_data));
                    check("stall_flags", 64'({sec_o, ded_o, synd_o}), 64'({h_sec, h_ded, h_synd}));
                end
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got vld_o 1, expected no word pending");
                end else begin
                    check("out_data", 64'(data_o), 64'(q[0].data));
                    check("out_sec", 64'(sec_o), 64'(q[0].sec));
                    check("out_ded", 64'(ded_o), 64'(q[0].ded));
                    check("out_synd", 64'(synd_o), 64'(q[0].synd));
                end
                held = !rdy_i;
                h_data = data_o; h_sec = sec_o; h_ded = ded_o; h_synd = synd_o;
            end else begin
                held = 1'b0;
            end
            if (log_clr) begin
                m_sec = 0; m_ded = 0; m_lvld = 1'b0; m_laddr = '0; m_lsynd = '0;
            end
            if (vld_o && rdy_i && q.size() != 0) begin
                e = q.pop_front();
                if (e.sec && m_sec < CNT_MAX) m_sec++;
                if (e.ded && m_ded < CNT_MAX) m_ded++;
                if ((e.sec || e.ded) && !m_lvld) begin
                    m_lvld = 1'b1; m_laddr = e.addr; m_lsynd = e.synd;
                end
            end
        end
    end

    vec_t          vt[9];
    logic [AW-1:0] ta, pa;
    logic [DW-1:0] td, pd;
    logic [CW-1:0] tc, pc;
    exp_t          te;
    bit            rnd_on;

    initial begin
        rst = 1'b1; vld_i = 1'b0; addr_i = '0; data_i = '0; corr_i = 1'b0;
        rdy_i = 1'b1; log_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld_o", 64'(vld_o), 64'd0);
        check("rst_data_o", 64'(data_o), 64'd0);
        check("rst_synd_o", 64'(synd_o), 64'd0);
        check("rst_cnts", 64'({sec_cnt, ded_cnt}), 64'd0);
        check("rst_log", 64'({log_vld, log_addr, log_synd}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_after_rst", 64'(rdy_o), 64'd1);
        @(posedge clk);
        #1;

        // Clean zero word, two-cycle latency
        vld_i = 1'b1; addr_i = '0; data_i = '0; corr_i = 1'b1;
        q.push_back(predict('0, '0, '0, 1'b1));
        @(posedge clk);
        #1;
        vld_i = 1'b0;
        @(negedge clk);
        check("latency_c1", 64'(vld_o), 64'd0);
        @(negedge clk);
        check("latency_c2", 64'(vld_o), 64'd1);
        @(posedge clk);
        #1;

        // Directed table
        td = 32'hDEADBEEF;
        ta = 18'h2A5A5;
        tc = enc(ta, td);
        vt[0] = mkvec('0, '0, '0, 1'b1, '0, 1'b0, 1'b0);
        vt[1] = mkvec(ta, td ^ 32'h20, tc, 1'b1, td, 1'b1, 1'b0);
        vt[2] = mkvec(ta, td ^ 32'h20, tc, 1'b0, td ^ 32'h20, 1'b1, 1'b0);
        vt[3] = mkvec(ta, td ^ 32'h3, tc, 1'b1, td ^ 32'h3, 1'b0, 1'b1);
        vt[4] = mkvec(ta, td, tc ^ 7'h01, 1'b1, td, 1'b1, 1'b0);
        vt[5] = mkvec(18'h00000, td, enc(18'h00001, td), 1'b1, td, 1'b0, 1'b1);
        vt[6] = mkvec(18'h3FFFF, 32'h12345678, enc(18'h3FFFF, 32'h12345678), 1'b1,
                      32'h12345678, 1'b0, 1'b0);
        vt[7] = mkvec(ta, td ^ 32'h80000000, tc, 1'b1, td, 1'b1, 1'b0);
        vt[8] = mkvec(ta, td, tc ^ 7'h40, 1'b0, td, 1'b1, 1'b0);
        for (int i = 0; i < 9; i++) begin
            te.addr = vt[i].addr;
            te.data = vt[i].exp_data;
            te.sec  = vt[i].exp_sec;
            te.ded  = vt[i].exp_ded;
            te.synd = synd_of(vt[i].addr, vt[i].data, vt[i].chk);
            send(vt[i].addr, {vt[i].chk, vt[i].data}, vt[i].corr, te);
        end
        drain();
        check("tbl_sec_cnt", 64'(sec_cnt), 64'd5);
        check("tbl_ded_cnt", 64'(ded_cnt), 64'd2);
        check("tbl_log_vld", 64'(log_vld), 64'd1);
        check("tbl_log_addr", 64'(log_addr), 64'(ta));

        // Eight back-to-back words with a three-cycle downstream stall
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    pa = AW'($urandom);
                    pd = $urandom;
                    send(pa, {enc(pa, pd), pd}, 1'b1, predict(pa, pd, enc(pa, pd), 1'b1));
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                rdy_i = 1'b0;
                @(posedge clk);
                #1;
                check("stall_rdy_o", 64'(rdy_o), 64'd0);
                repeat (2) @(posedge clk);
                #1;
                rdy_i = 1'b1;
            end
        join
        drain();

        // Random traffic with random backpressure and clear pulses
        rnd_on = 1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    int b1, b2;
                    ta = AW'($urandom);
                    td = $urandom;
                    tc = enc(ta, td);
                    pa = ta; pd = td; pc = tc;
                    b1 = $urandom_range(0, DW - 1);
                    b2 = (b1 + 1 + $urandom_range(0, DW - 2)) % DW;
                    case ($urandom_range(0, 4))
                        1: pd[b1] = ~pd[b1];
                        2: begin pd[b1] = ~pd[b1]; pd[b2] = ~pd[b2]; end
                        3: pc[$urandom_range(0, CW - 1)] ^= 1'b1;
                        4: pa[$urandom_range(0, AW - 1)] ^= 1'b1;
                        default: ;
                    endcase
                    corr_i = $urandom_range(0, 1) != 0;
                    send(pa, {pc, pd}, corr_i, predict(pa, pd, pc, corr_i));
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    rdy_i   = ($urandom_range(0, 3) != 0);
                    log_clr = ($urandom_range(0, 19) == 0);
                end
                rdy_i   = 1'b1;
                log_clr = 1'b0;
            end
        join
        drain();

        // Saturation of the SEC counter
        log_clr = 1'b1;
        @(posedge clk);
        #1;
        log_clr = 1'b0;
        for (int n = 0; n < (1 << NW) + 2; n++) begin
            pa = AW'($urandom);
            td = $urandom;
            pd = td ^ (32'h1 << (n % DW));
            send(pa, {enc(pa, td), pd}, 1'b1, predict(pa, pd, enc(pa, td), 1'b1));
        end
        drain();
        check("sec_saturated", 64'(sec_cnt), 64'(CNT_MAX));

        // Clear coinciding with an SEC handshake
        rdy_i = 1'b0;
        pa = 18'h15555;
        td = 32'hCAFEF00D;
        pd = td ^ 32'h100;
        send(pa, {enc(pa, td), pd}, 1'b1, predict(pa, pd, enc(pa, td), 1'b1));
        for (int i = 0; i < 20 && !vld_o; i++) begin
            @(posedge clk);
            #1;
        end
        check("clr_hs_vld_o", 64'(vld_o), 64'd1);
        rdy_i   = 1'b1;
        log_clr = 1'b1;
        @(posedge clk);
        #1;
        log_clr = 1'b0;
        check("clr_hs_sec_cnt", 64'(sec_cnt), 64'd1);
        check("clr_hs_log_vld", 64'(log_vld), 64'd1);
        check("clr_hs_log_addr", 64'(log_addr), 64'(pa));
        drain();

        // Reset with two DED words in flight
        log_clr = 1'b1;
        @(posedge clk);
        #1;
        log_clr = 1'b0;
        rdy_i = 1'b0;
        for (int n = 0; n < 2; n++) begin
            pa = AW'($urandom);
            td = $urandom;
            pd = td ^ 32'h3;
            send(pa, {enc(pa, td), pd}, 1'b1, predict(pa, pd, enc(pa, td), 1'b1));
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("flush_vld_o", 64'(vld_o), 64'd0);
        rst = 1'b0;
        rdy_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("flush_no_out", 64'(vld_o), 64'd0);
        check("flush_ded_cnt", 64'(ded_cnt), 64'd0);
        check("flush_log_vld", 64'(log_vld), 64'd0);
        check("flush_rdy_o", 64'(rdy_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ms_hsiao_ecc_check.md
MS_HSIAO_ECC_CHECK -- requirements
Module: ms_hsiao_ecc_check

Interface
REQ-001 Parameter CDataW, default 32, protected data width.
REQ-002 Parameter CAddrW, default 18, address bits folded into the check bits but not stored.
REQ-003 Parameter CChkW, default 7, stored check-bit width.
REQ-004 Parameter CSens, CChkW rows of (CAddrW+CDataW) bits, row i selecting the {addr,data} bits that feed check bit i; default rows (MSB row first) 50'h054F7C5C35996, 50'h22AED9C3C5553, 50'h161DE5999AC39, 50'h098BFCA55A3C9, 50'h3867A35CC9335, 50'h381F933335CCC, 50'h07F0733333333.
REQ-005 Parameter CCntW, default 16, width of the error counters.
REQ-006 AClkH  in  1  single clock; all state rising-edge.
REQ-007 AResetH  in  1  asynchronous, active-high reset.
REQ-008 AVldI  in  1  input word valid.
REQ-009 ARdyO  out  1  block accepts the input word this cycle.
REQ-010 AAddrI  in  CAddrW  address of the word read.
REQ-011 ADataI  in  CChkW+CDataW  stored word {check, data}.
REQ-012 ACorrEn  in  1  1 = correct single-bit data errors; 0 = pass data raw and flag only.
REQ-013 AVldO  out  1  output word valid.
REQ-014 ARdyI  in  1  downstream accepts the output word.
REQ-015 ADataO  out  CDataW  corrected (or raw) data.
REQ-016 ASecO  out  1  single-bit error seen (data or check bit).
REQ-017 ADedO  out  1  uncorrectable error (even-weight syndrome, address-column match, or non-column odd syndrome).
REQ-018 ASyndO  out  CChkW  syndrome of the output word.
REQ-019 ASecCnt, ADedCnt  out  CCntW  saturating error counts.
REQ-020 ALogVld  out  1, ALogAddr  out  CAddrW, ALogSynd  out  CChkW  first-error capture.
REQ-021 ALogClr  in  1  one-cycle pulse; clears counters and the capture.

Function
REQ-022 The syndrome SHALL be S[i] = XOR(({AAddrI,data} & CSens row i)) XOR check[i].
REQ-023 Classification SHALL be: S=0 clean; S equal to a data-bit column of CSens -> SEC, flip that bit; S equal to a unit vector -> SEC, check-bit error, data unchanged; S equal to an address-bit column -> DED; S even weight nonzero -> DED; any other S -> DED.
REQ-024 The pipeline SHALL be two stages: stage 1 registers the address, word and syndrome; stage 2 registers the corrected data and flags; latency 2 cycles from an accepted input to AVldO with no stall.
REQ-025 Each stage SHALL advance when it is empty or the next stage advances; ARdyO = ~stage1-full | stage1-advances, with stage 2 advancing on ~AVldO | ARdyI.
REQ-026 ADataO, ASecO, ADedO and ASyndO SHALL hold stable while AVldO=1 & ARdyI=0.
REQ-027 With ACorrEn=0, ADataO SHALL equal the raw data, and the flags SHALL be unchanged; ACorrEn is sampled in stage 1.
REQ-028 The counters SHALL increment once per output handshake (AVldO & ARdyI) carrying SEC/DED and saturate at all-ones.
REQ-029 The capture SHALL load address and syndrome at the first SEC or DED handshake while ALogVld=0, and hold until ALogClr.
REQ-030 ALogClr coinciding with an error handshake SHALL clear first, then count/capture that error (count = 1, ALogVld = 1).
REQ-031 Throughput SHALL be one word per cycle with ARdyI held high.

Reset
REQ-032 AResetH SHALL clear both stage valids, counters, ALogVld, ALogAddr, ALogSynd, ADataO and ASyndO to 0 immediately; ARdyO=1 on the first cycle after release.
REQ-033 Words in flight at reset SHALL be discarded without being counted or logged.

Verification
REQ-034 Clean word addr 0, data 0, check 0 -> AVldO two cycles later, ADataO 0, ASyndO 0, ASecO=ADedO=0.
REQ-035 Encoded word with data bit 5 flipped, ACorrEn=1 -> ADataO = original, ASecO=1, ASecCnt=1, ALogVld=1 with ALogAddr = input address; repeat with ACorrEn=0 -> raw data, ASecO=1.
REQ-036 Data bits 0 and 1 flipped -> ADedO=1, ADedCnt increments; check-bit 0 flipped -> ASecO=1, data unchanged.
REQ-037 Encode with addr 0x00001, present with addr 0x00000 -> ADedO=1 (address error).
REQ-038 Back-to-back 8 words with ARdyI low for 3 cycles mid-stream -> no loss or duplication, outputs stable while stalled, ARdyO drops when both stages full.
REQ-039 Force 2^CCntW+2 SEC words -> ASecCnt saturates at all-ones; ALogClr in the same cycle as an SEC handshake -> ASecCnt=1.
